// File: rtl/sfu_acc.sv
// Special-function accumulator: reduces a stream of psum vectors into one
// result vector per group (sum or signed max), with optional ReLU and saturation.
module sfu_acc #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   psum_in,
  input  logic [cnt_bw-1:0]        acc_len,
  input  logic                     mode,
  input  logic                     relu_en,
  input  logic                     sat_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   psum_out,
  output logic [col-1:0]           ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r;
  logic [col*psum_bw-1:0]   acc_r;
  logic [col*psum_bw-1:0]   nxt_acc_s;
  logic [col-1:0]           ovf_r;
  logic [col-1:0]           nxt_ovf_s;
  logic [cnt_bw-1:0]        rem_r;
  logic                     mode_r;
  logic                     relu_r;
  logic                     sat_r;
  logic                     out_valid_r;
  logic                     beat_s;

  // Returns {overflow, new_lane}; the extra MSB of the add is the true sign,
  // so overflow is simply a disagreement between the top two sum bits.
  function automatic logic [psum_bw:0] lane_step(
    input logic [psum_bw-1:0] a,
    input logic [psum_bw-1:0] b,
    input logic               max_mode,
    input logic               sat
  );
    logic [psum_bw:0]   full;
    logic [psum_bw-1:0] res;
    logic               ovf;
    full = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    ovf  = 1'b0;
    if (max_mode) begin
      res = ($signed(b) > $signed(a)) ? b : a;
    end else begin
      ovf = full[psum_bw] ^ full[psum_bw-1];
      if (ovf && sat) begin
        res = full[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
        res = full[psum_bw-1:0];
      end
    end
    return {ovf, res};
  endfunction

  assign in_ready  = !reset && (state_r != DONE);
  assign beat_s    = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign ovf_o     = ovf_r;

  // Per-lane next accumulator value and overflow for an accepted beat
  always_comb begin
    nxt_acc_s = acc_r;
    nxt_ovf_s = '0;
    for (int k = 0; k < col; k++) begin
      {nxt_ovf_s[k], nxt_acc_s[k*psum_bw +: psum_bw]} =
        lane_step(acc_r[k*psum_bw +: psum_bw], psum_in[k*psum_bw +: psum_bw], mode_r, sat_r);
    end
  end

  // Output lanes with optional ReLU clamp
  always_comb begin
    psum_out = '0;
    for (int k = 0; k < col; k++) begin
      if (relu_r && acc_r[k*psum_bw + psum_bw - 1]) begin
        psum_out[k*psum_bw +: psum_bw] = '0;
      end else begin
        psum_out[k*psum_bw +: psum_bw] = acc_r[k*psum_bw +: psum_bw];
      end
    end
  end

  // Group FSM: first beat loads config and accumulator, last beat moves to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      ovf_r       <= '0;
      rem_r       <= '0;
      mode_r      <= 1'b0;
      relu_r      <= 1'b0;
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (beat_s) begin
            mode_r <= mode;
            relu_r <= relu_en;
            sat_r  <= sat_en;
            acc_r  <= psum_in;
            ovf_r  <= '0;
            rem_r  <= acc_len;
            if (acc_len == '0) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ACC;
            end
          end
        end
        ACC: begin
          if (beat_s) begin
            acc_r <= nxt_acc_s;
            ovf_r <= ovf_r | nxt_ovf_s;
            rem_r <= rem_r - cnt_bw'(1);
            if (rem_r == cnt_bw'(1)) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfu_acc.sv
// Self-checking bench for sfu_acc: group-level reference model compared every
// cycle, plus directed literal expectations.
module tb_sfu_acc;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int CB  = 8;
  localparam int W   = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  psum_in = '0;
  logic [CB-1:0] acc_len = '0;
  logic          mode = 1'b0;
  logic          relu_en = 1'b0;
  logic          sat_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  psum_out;
  logic [COL-1:0] ovf_o;

  int errs = 0;
  int checks = 0;
  bit chk_on = 0;
  logic [W-1:0] gdata [256];
  logic [W-1:0] res;
  logic [COL-1:0] resf;

  always #5 clk = ~clk;

  sfu_acc #(.col(COL), .psum_bw(BW), .cnt_bw(CB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .psum_in(psum_in), .acc_len(acc_len), .mode(mode), .relu_en(relu_en),
    .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
    .psum_out(psum_out), .ovf_o(ovf_o)
  );

  // ---------------- reference model (group-level arithmetic) ----------------
  int m_acc [COL];
  logic [COL-1:0] m_ovf = '0;
  logic [W-1:0] m_out = '0;
  bit m_pending = 0;
  int m_cnt = 0;
  int m_len = 0;
  bit m_mode, m_relu, m_sat;
  wire m_ready = !reset && !m_pending;

  function automatic int lane(input logic [W-1:0] d, input int k);
    logic [BW-1:0] v;
    v = d[k*BW +: BW];
    return int'($signed(v));
  endfunction

  function automatic logic [W-1:0] ln(input logic [W-1:0] d, input int k);
    return W'(d[k*BW +: BW]);
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_pending = 0;
      m_cnt = 0;
    end else if (m_pending) begin
      if (out_ready) m_pending = 0;
    end else if (in_valid) begin
      if (m_cnt == 0) begin
        m_len = int'(acc_len);
        m_mode = mode; m_relu = relu_en; m_sat = sat_en;
        m_ovf = '0;
        for (int k = 0; k < COL; k++) m_acc[k] = lane(psum_in, k);
      end else begin
        for (int k = 0; k < COL; k++) begin
          int x, t;
          x = lane(psum_in, k);
          if (m_mode) begin
            if (x > m_acc[k]) m_acc[k] = x;
          end else begin
            t = m_acc[k] + x;
            if (t > 32767 || t < -32768) begin
              m_ovf[k] = 1'b1;
              if (m_sat) t = (t > 0) ? 32767 : -32768;
              else t = (t > 0) ? t - 65536 : t + 65536;
            end
            m_acc[k] = t;
          end
        end
      end
      m_cnt++;
      if (m_cnt == m_len + 1) begin
        for (int k = 0; k < COL; k++)
          m_out[k*BW +: BW] = (m_relu && m_acc[k] < 0) ? 16'd0 : 16'(m_acc[k]);
        m_pending = 1;
        m_cnt = 0;
      end
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("in_ready", W'(in_ready), W'(m_ready));
      check("out_valid", W'(out_valid), W'(m_pending));
      if (m_pending) begin
        check("psum_out", psum_out, m_out);
        check("ovf_o", W'(ovf_o), W'(m_ovf));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic [CB-1:0] len,
                           input logic m, input logic r, input logic s);
    int g = 0;
    in_valid = 1'b1; psum_in = d; acc_len = len; mode = m; relu_en = r; sat_en = s;
    while (!m_ready && g < 40) begin step(); g++; end
    if (g >= 40) check("accept_timeout", W'(1), W'(0));
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_group(input int n, input logic m, input logic r, input logic s, input bit rnd);
    for (int j = 0; j < n; j++) begin
      if (rnd) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      if (j == 0 || !rnd) send_beat(gdata[j], CB'(n - 1), m, r, s);
      else send_beat(gdata[j], CB'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic grab(input string nm);
    int g = 0;
    @(negedge clk);
    while (!out_valid && g < 40) begin @(negedge clk); g++; end
    if (g >= 40) check({nm, "_timeout"}, W'(0), W'(1));
    res = psum_out;
    resf = ovf_o;
    step();
  endtask

  task automatic clr(input int n);
    for (int j = 0; j < n; j++) gdata[j] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset
    repeat (3) step();
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(0));
    step();
    reset = 1'b0;
    chk_on = 1;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_psum_out", psum_out, W'(0));
    check("rst_ovf", W'(ovf_o), W'(0));
    step();

    // sum, 4 beats, lane k adds k
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < COL; k++) gdata[j][k*BW +: BW] = 16'(j + 1 + k);
    send_group(4, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("t1_latency", W'(out_valid), W'(1));
    check("t1_lane0", ln(psum_out, 0), W'(16'd10));
    check("t1_lane3", ln(psum_out, 3), W'(16'd22));
    check("t1_lane7", ln(psum_out, 7), W'(16'd38));
    check("t1_ovf", W'(ovf_o), W'(0));
    @(negedge clk);
    check("t1_single_pulse", W'(out_valid), W'(0));
    step();

    // saturation / wrap
    clr(2);
    gdata[0][15:0] = 16'd30000; gdata[1][15:0] = 16'd10000;
    send_group(2, 1'b0, 1'b0, 1'b1, 0);
    grab("t2");
    check("t2_sat_lane0", ln(res, 0), W'(16'h7FFF));
    check("t2_sat_ovf", W'(resf), W'(8'h01));
    send_group(2, 1'b0, 1'b0, 1'b0, 0);
    grab("t2w");
    check("t2_wrap_lane0", ln(res, 0), W'(16'h9C40));
    check("t2_wrap_ovf", W'(resf), W'(8'h01));
    gdata[0][15:0] = 16'd5; gdata[1][15:0] = 16'd6;
    send_group(2, 1'b0, 1'b0, 1'b1, 0);
    grab("t2s");
    check("t2_small_lane0", ln(res, 0), W'(16'd11));
    check("t2_small_ovf", W'(resf), W'(0));

    // max mode with and without relu
    clr(3);
    gdata[0][15:0] = -16'sd5; gdata[1][15:0] = -16'sd2; gdata[2][15:0] = -16'sd9;
    gdata[0][31:16] = -16'sd5; gdata[1][31:16] = 16'sd7; gdata[2][31:16] = 16'sd3;
    send_group(3, 1'b1, 1'b1, 1'b0, 0);
    grab("t3");
    check("t3_relu_lane0", ln(res, 0), W'(0));
    check("t3_relu_lane1", ln(res, 1), W'(16'd7));
    send_group(3, 1'b1, 1'b0, 1'b0, 0);
    grab("t3n");
    check("t3_norelu_lane0", ln(res, 0), W'(16'hFFFE));

    // backpressure: result held, offered beats refused
    for (int k = 0; k < COL; k++) begin
      gdata[0][k*BW +: BW] = 16'(100 + k);
      gdata[1][k*BW +: BW] = 16'(-3 * k);
    end
    out_ready = 1'b0;
    send_group(2, 1'b0, 1'b0, 1'b0, 0);
    in_valid = 1'b1; psum_in = {4{$urandom()}}; acc_len = '0;
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_ready", W'(in_ready), W'(0));
      check("t4_hold_lane1", ln(psum_out, 1), W'(16'd98));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("t4_idle_ready", W'(in_ready), W'(1));
    step();
    send_group(2, 1'b0, 1'b0, 1'b0, 0);
    grab("t4n");
    check("t4_next_lane7", ln(res, 7), W'(16'd86));

    // random groups with bubbles and scrambled non-first config
    for (int g = 0; g < 20; g++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) gdata[j] = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_group(n, 1'($urandom), 1'($urandom), 1'($urandom), 1);
    end
    // single-beat groups back to back
    for (int g = 0; g < 8; g++) begin
      gdata[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_group(1, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    // maximum group length: 256 beats of +1
    for (int j = 0; j < 256; j++)
      for (int k = 0; k < COL; k++) gdata[j][k*BW +: BW] = 16'd1;
    send_group(256, 1'b0, 1'b0, 1'b0, 0);
    grab("t6");
    check("t6_len256_lane0", ln(res, 0), W'(16'd256));

    // reset mid-group
    for (int k = 0; k < COL; k++) gdata[0][k*BW +: BW] = 16'(1000 + k);
    send_beat(gdata[0], CB'(3), 1'b0, 1'b0, 1'b0);
    send_beat(gdata[0], CB'(3), 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("t7_rst_ready", W'(in_ready), W'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t7_rst_valid", W'(out_valid), W'(0));
    check("t7_rst_psum", psum_out, W'(0));
    step();
    clr(2);
    gdata[0][15:0] = 16'd7; gdata[1][15:0] = 16'd8;
    send_group(2, 1'b0, 1'b0, 1'b0, 0);
    grab("t7a");
    check("t7_after_lane0", ln(res, 0), W'(16'd15));

    // reset while holding a result
    out_ready = 1'b0;
    gdata[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_group(1, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t8_rst_valid", W'(out_valid), W'(0));
    check("t8_rst_psum", psum_out, W'(0));
    check("t8_rst_ovf", W'(ovf_o), W'(0));
    out_ready = 1'b1;
    step();
    clr(2);
    gdata[0][31:16] = 16'd20; gdata[1][31:16] = -16'sd4;
    send_group(2, 1'b0, 1'b0, 1'b0, 0);
    grab("t8a");
    check("t8_after_lane1", ln(res, 1), W'(16'd16));
    check("t8_after_lane0", ln(res, 0), W'(0));

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sfu_acc.md
# sfu_acc

Parametrised special-function unit that reduces a stream of partial-sum vectors from the systolic array into one result vector per group, then applies optional ReLU. Successor to the fixed single-mode accumulator: adds a programmable group length, sum or running-max reduction, optional saturation, per-column overflow flags and a valid/ready output handshake. Sits between the array's psum output and the output SRAM write port.

## Interface
- col, 8, number of independent columns (lanes)
- psum_bw, 16, width of each signed lane
- cnt_bw, 8, width of the group-length field
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  psum_in beat offered
- in_ready  out  1  block accepts a beat; combinational, = !reset && state!=DONE
- psum_in  in  col*psum_bw  input lanes, lane k at [(k+1)*psum_bw-1 : k*psum_bw], two's complement
- acc_len  in  cnt_bw  group length minus one (0 = 1 beat, max 2^cnt_bw beats); sampled on a group's first beat
- mode  in  1  0 = sum, 1 = signed max; sampled on first beat
- relu_en  in  1  clamp negative results to 0 at output; sampled on first beat
- sat_en  in  1  saturating add in sum mode; sampled on first beat
- out_valid  out  1  result available (registered)
- out_ready  in  1  consumer takes result
- psum_out  out  col*psum_bw  result lanes, same packing as psum_in
- ovf_o  out  col  per-lane sticky overflow for the current group

## Operation
- Beat accepted when in_valid && in_ready.
- FSM states: IDLE, ACC, DONE. Reset -> IDLE.
- IDLE: on accepted beat, latch mode/relu_en/sat_en, load acc_q = psum_in, clear ovf, rem_q = acc_len. If acc_len==0 -> DONE, else -> ACC. No beat: stay.
- ACC: on accepted beat, update every lane of acc_q, rem_q -= 1; if rem_q==1 before the decrement (last beat) -> DONE. No beat: hold all state.
- DONE: out_valid=1, in_ready=0; acc_q, ovf, psum_out frozen. On out_ready -> IDLE. No beat accepted in DONE, even with out_ready high in the same cycle.
- Sum mode: full-precision signed add of acc lane + input lane. Overflow = operand signs equal and differ from result sign. sat_en=1: clamp to 2^(psum_bw-1)-1 or -2^(psum_bw-1). sat_en=0: wrap modulo 2^psum_bw. Either way, overflow sets that lane's ovf bit, which stays set until the next group's first beat.
- Max mode: acc lane = signed max(acc, input). sat_en ignored, ovf never set.
- psum_out lane = (relu_en && acc lane MSB) ? 0 : acc lane. Combinational from acc_q and latched relu_en; only meaningful while out_valid=1.
- Config inputs are ignored on every beat other than a group's first beat.
- Lanes are fully independent; no cross-lane carry.

## Timing
- Reset (synchronous, edge with reset=1): state=IDLE, acc_q=0, rem_q=0, ovf_o=0, out_valid=0, psum_out=0, latched config=0. in_ready=0 while reset is high.
- Reset mid-group or in DONE discards the partial result; no output is produced.
- Latency: last beat accepted at edge t -> out_valid=1 from edge t, visible in cycle t+1.
- Back-to-back groups of N beats with in_valid and out_ready held high: one result every N+1 cycles.
- out_valid stays high with psum_out/ovf_o stable until the edge where out_ready=1.
- acc_len = 2^cnt_bw-1 gives 2^cnt_bw beats; rem_q needs no extra width.

## Test plan
- col=8, psum_bw=16, sum mode, acc_len=3, lanes fed 1,2,3,4 (lane k adds k) -> one out_valid; lane k = 10+4k; ovf_o=0; out_valid seen exactly 1 cycle after 4th beat.
- Sum, sat_en=1, lane0 fed 30000 then 10000 (acc_len=1) -> lane0=32767, ovf_o[0]=1. Repeat with sat_en=0 -> lane0=-25536, ovf_o[0]=1. Next group with small values -> ovf_o[0]=0.
- Max mode, relu_en=1, lane0 fed -5,-2,-9 and lane1 fed -5,7,3 (acc_len=2) -> lane0=0, lane1=7. Same with relu_en=0 -> lane0=-2.
- Backpressure: out_ready low for 5 cycles after result -> out_valid/psum_out stable, in_ready=0, in_valid beats not accepted; out_ready high -> IDLE next cycle, next group correct.
- in_valid gaps inside a group (random bubbles), acc_len=0 single-beat groups back-to-back, and config changed on non-first beats -> results match the reference model; config changes have no effect.
- reset asserted mid-ACC and again in DONE -> out_valid=0, psum_out=0 next cycle; following group result uncontaminated.
